// File: rtl/vx_cta_dispatch_mq.sv
// vx_cta_dispatch_mq
//   Queues CTA descriptors and hands their warps one at a time to free warp
//   slots. A warp slot is free when it is neither running (active_warps) nor
//   claimed by a dispatch the scheduler has not yet retired. A claim ends on
//   the cycle the slot's active bit falls 1->0.
//
// Ports
//   clk, reset        : clock, synchronous active-low reset
//   req_*             : CTA descriptor valid/ready push interface
//   active_warps      : per-slot running flags from the warp scheduler
//   sched_valid/_wid  : one-cycle dispatch pulse and the slot it targets
//   pc .. tmask       : per-slot start state, updated only when dispatched
//   queue_count, busy : queue occupancy, activity flag

module vx_cta_dispatch_mq #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned NWC_W       = 8,
  localparam int unsigned WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int unsigned QA_W       = $clog2(QUEUE_DEPTH),
  localparam int unsigned QC_W       = QA_W + 1
) (
  input  logic                                    clk,
  input  logic                                    reset,

  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic [XLEN-1:0]                         req_pc,
  input  logic [XLEN-1:0]                         req_param,
  input  logic [31:0]                             req_cta_x,
  input  logic [31:0]                             req_cta_y,
  input  logic [31:0]                             req_cta_z,
  input  logic [31:0]                             req_cta_id,
  input  logic [NWC_W-1:0]                        req_num_warps,
  input  logic [NUM_THREADS-1:0]                  req_remain_mask,

  input  logic [NUM_WARPS-1:0]                    active_warps,

  output logic                                    sched_valid,
  output logic [WID_W-1:0]                        sched_wid,
  output logic [NUM_WARPS-1:0][XLEN-1:0]          pc,
  output logic [NUM_WARPS-1:0][XLEN-1:0]          param,
  output logic [NUM_WARPS-1:0][31:0]              cta_x,
  output logic [NUM_WARPS-1:0][31:0]              cta_y,
  output logic [NUM_WARPS-1:0][31:0]              cta_z,
  output logic [NUM_WARPS-1:0][31:0]              cta_id,
  output logic [NUM_WARPS-1:0][NWC_W-1:0]         warp_in_cta,
  output logic [NUM_WARPS-1:0][NUM_THREADS-1:0]   tmask,
  output logic [QC_W-1:0]                         queue_count,
  output logic                                    busy
);

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        param;
    logic [31:0]            cta_x;
    logic [31:0]            cta_y;
    logic [31:0]            cta_z;
    logic [31:0]            cta_id;
    logic [NWC_W-1:0]       num_warps;
    logic [NUM_THREADS-1:0] remain_mask;
  } desc_t;

  typedef enum logic {
    IDLE     = 1'b0,
    DISPATCH = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  desc_t                  fifo_q [QUEUE_DEPTH];
  desc_t                  cur_q;
  desc_t                  desc_in_c;
  logic [QA_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [QC_W-1:0]        count_d;
  logic [NWC_W-1:0]       k_q;
  logic [NUM_WARPS-1:0]   claimed_q, active_prev_q;
  logic [NUM_WARPS-1:0]   free_c, retire_c, disp_onehot_c;
  logic [WID_W-1:0]       sel_c;
  logic                   any_free_c, is_last_c;
  logic                   push_c, pop_c, dispatch_c;

  // Incoming descriptor bundle
  always_comb begin
    desc_in_c             = '0;
    desc_in_c.pc          = req_pc;
    desc_in_c.param       = req_param;
    desc_in_c.cta_x       = req_cta_x;
    desc_in_c.cta_y       = req_cta_y;
    desc_in_c.cta_z       = req_cta_z;
    desc_in_c.cta_id      = req_cta_id;
    desc_in_c.num_warps   = req_num_warps;
    desc_in_c.remain_mask = req_remain_mask;
  end

  // Slot availability and lowest-index free slot
  always_comb begin
    retire_c   = active_prev_q & ~active_warps;
    free_c     = ~(active_warps | claimed_q);
    sel_c      = '0;
    any_free_c = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (free_c[i] && !any_free_c) begin
        sel_c      = WID_W'(i);
        any_free_c = 1'b1;
      end
    end
    is_last_c = (k_q == (cur_q.num_warps - NWC_W'(1)));
  end

  // Next-state and control; the queue is only drained from IDLE
  always_comb begin
    state_d    = state_q;
    pop_c      = 1'b0;
    dispatch_c = 1'b0;
    push_c     = req_valid && req_ready;
    case (state_q)
      IDLE: begin
        if (queue_count != '0) begin
          pop_c = 1'b1;
          // Zero-warp CTAs are dropped on the pop itself
          if (fifo_q[rd_ptr_q].num_warps != '0) begin
            state_d = DISPATCH;
          end
        end
      end
      DISPATCH: begin
        if (any_free_c) begin
          dispatch_c = 1'b1;
          if (is_last_c) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_d = queue_count;
    case ({push_c, pop_c})
      2'b10:   count_d = queue_count + QC_W'(1);
      2'b01:   count_d = queue_count - QC_W'(1);
      default: count_d = queue_count;
    endcase
  end

  always_comb begin
    disp_onehot_c = '0;
    if (dispatch_c) begin
      disp_onehot_c[sel_c] = 1'b1;
    end
  end

  // Descriptor storage; validity is tracked by pointers and count only
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_q[wr_ptr_q] <= desc_in_c;
    end
  end

  // Control state, queue pointers, status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      queue_count   <= '0;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      cur_q         <= '0;
      k_q           <= '0;
      claimed_q     <= '0;
      active_prev_q <= '0;
    end else begin
      state_q       <= state_d;
      queue_count   <= count_d;
      req_ready     <= (count_d < QC_W'(QUEUE_DEPTH));
      busy          <= (count_d != '0) || (state_d != IDLE);
      active_prev_q <= active_warps;
      // A dispatch wins over a retirement landing on the same slot
      claimed_q     <= (claimed_q & ~retire_c) | disp_onehot_c;
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + QA_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + QA_W'(1);
        cur_q    <= fifo_q[rd_ptr_q];
        k_q      <= '0;
      end else if (dispatch_c) begin
        k_q <= k_q + NWC_W'(1);
      end
    end
  end

  // Per-slot start state, written only for the slot being dispatched
  always_ff @(posedge clk) begin
    if (!reset) begin
      sched_valid <= 1'b0;
      sched_wid   <= '0;
      pc          <= '0;
      param       <= '0;
      cta_x       <= '0;
      cta_y       <= '0;
      cta_z       <= '0;
      cta_id      <= '0;
      warp_in_cta <= '0;
      tmask       <= '0;
    end else begin
      sched_valid <= dispatch_c;
      if (dispatch_c) begin
        sched_wid          <= sel_c;
        pc[sel_c]          <= cur_q.pc;
        param[sel_c]       <= cur_q.param;
        cta_x[sel_c]       <= cur_q.cta_x;
        cta_y[sel_c]       <= cur_q.cta_y;
        cta_z[sel_c]       <= cur_q.cta_z;
        cta_id[sel_c]      <= cur_q.cta_id;
        warp_in_cta[sel_c] <= k_q;
        tmask[sel_c]       <= is_last_c ? cur_q.remain_mask : '1;
      end
    end
  end

endmodule
